// File: rtl/fight_pkg.sv
// Shared definitions for the fight core: round state encoding, attack codes
// and round-winner encoding. Imported by hp_channel and fight_health_ctrl.
package fight_pkg;

  typedef enum logic [1:0] {
    ST_FIGHT      = 2'b00,
    ST_KO_HOLD    = 2'b01,
    ST_ROUND_END  = 2'b10,
    ST_MATCH_OVER = 2'b11
  } fight_state_t;

  localparam logic [1:0] ATK_NONE  = 2'b00;
  localparam logic [1:0] ATK_LIGHT = 2'b01;
  localparam logic [1:0] ATK_MED   = 2'b10;
  localparam logic [1:0] ATK_HEAVY = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/hp_channel.sv
// One player's health channel: health register, damage lookup with
// saturating subtract, and the post-hit invulnerability counter.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   frame_tick   - per-frame strobe, decrements the invulnerability counter
//   enable       - damage allowed (round is in FIGHT)
//   hit          - attacker's hitbox overlaps this player's hurtbox
//   atk          - attacker's attack code
//   clear        - round restart: health to HP_MAX, counter to 0
//   health       - current health
//   invuln       - invulnerability counter is nonzero
//   zero_next    - health will be zero after this edge (KO detection)
module hp_channel
  import fight_pkg::*;
#(
  parameter int HP_MAX    = 200,
  parameter int HP_W      = 9,
  parameter int DMG_LIGHT = 4,
  parameter int DMG_MED   = 10,
  parameter int DMG_HEAVY = 40,
  parameter int IFRAMES   = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_tick,
  input  logic            enable,
  input  logic            hit,
  input  logic [1:0]      atk,
  input  logic            clear,
  output logic [HP_W-1:0] health,
  output logic            invuln,
  output logic            zero_next
);

  localparam int CNT_W = $clog2(IFRAMES + 1);

  logic [HP_W-1:0]  health_reg, health_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [HP_W-1:0]  dmg;
  logic             hit_valid;

  always_comb begin
    dmg = '0;
    case (atk)
      ATK_LIGHT: dmg = HP_W'(DMG_LIGHT);
      ATK_MED:   dmg = HP_W'(DMG_MED);
      ATK_HEAVY: dmg = HP_W'(DMG_HEAVY);
      default:   dmg = '0;
    endcase
  end

  assign hit_valid = enable && hit && (atk != ATK_NONE) && (cnt_reg == '0);

  always_comb begin
    health_next = health_reg;
    cnt_next    = cnt_reg;
    if (clear) begin
      health_next = HP_W'(HP_MAX);
      cnt_next    = '0;
    end else if (hit_valid) begin
      // Saturate at zero instead of wrapping.
      health_next = (health_reg > dmg) ? (health_reg - dmg) : '0;
      cnt_next    = CNT_W'(IFRAMES);
    end else if (frame_tick && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      health_reg <= HP_W'(HP_MAX);
      cnt_reg    <= '0;
    end else begin
      health_reg <= health_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign health    = health_reg;
  assign invuln    = (cnt_reg != '0);
  // Only meaningful while enable is high; the top gates it with FIGHT.
  assign zero_next = (health_next == '0);

endmodule

// File: rtl/fight_health_ctrl.sv
// Two-player health, invulnerability and round/match controller.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   frame_tick          - per-frame strobe
//   hit_p1 / hit_p2     - P1 hits P2 / P2 hits P1 overlap flags
//   atk_p1 / atk_p2     - attack codes (00 none, 01 light, 10 med, 11 heavy)
//   round_start         - advances out of ROUND_END or MATCH_OVER
//   health_1/2          - current health
//   invuln_1/2          - player's invulnerability counter nonzero
//   wins_1/2            - round wins (saturating)
//   state               - 00 FIGHT, 01 KO_HOLD, 10 ROUND_END, 11 MATCH_OVER
//   winner              - last decided round: 00 none, 01 P1, 10 P2, 11 draw
//   ko_pulse            - one-cycle strobe after the KO edge
module fight_health_ctrl
  import fight_pkg::*;
#(
  parameter int HP_MAX         = 200,
  parameter int HP_W           = 9,
  parameter int DMG_LIGHT      = 4,
  parameter int DMG_MED        = 10,
  parameter int DMG_HEAVY      = 40,
  parameter int IFRAMES        = 30,
  parameter int KO_HOLD_FRAMES = 120,
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int WIN_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             hit_p1,
  input  logic             hit_p2,
  input  logic [1:0]       atk_p1,
  input  logic [1:0]       atk_p2,
  input  logic             round_start,
  output logic [HP_W-1:0]  health_1,
  output logic [HP_W-1:0]  health_2,
  output logic             invuln_1,
  output logic             invuln_2,
  output logic [WIN_W-1:0] wins_1,
  output logic [WIN_W-1:0] wins_2,
  output logic [1:0]       state,
  output logic [1:0]       winner,
  output logic             ko_pulse
);

  localparam int KO_W = $clog2(KO_HOLD_FRAMES + 1);

  fight_state_t     state_reg, state_next;
  logic [KO_W-1:0]  ko_cnt_reg, ko_cnt_next;
  logic [WIN_W-1:0] wins_1_reg, wins_1_next, wins_2_reg, wins_2_next;
  logic [1:0]       winner_reg, winner_next;
  logic             ko_pulse_reg, ko_pulse_next;
  logic             round_clear;
  logic             fighting;
  logic             zero_1, zero_2;

  assign fighting = (state_reg == ST_FIGHT);

  // Channel 1 is P1's health, damaged by P2's attacks; channel 2 the reverse.
  hp_channel #(
    .HP_MAX(HP_MAX), .HP_W(HP_W), .DMG_LIGHT(DMG_LIGHT), .DMG_MED(DMG_MED),
    .DMG_HEAVY(DMG_HEAVY), .IFRAMES(IFRAMES)
  ) u_ch1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(fighting),
    .hit(hit_p2), .atk(atk_p2), .clear(round_clear),
    .health(health_1), .invuln(invuln_1), .zero_next(zero_1)
  );

  hp_channel #(
    .HP_MAX(HP_MAX), .HP_W(HP_W), .DMG_LIGHT(DMG_LIGHT), .DMG_MED(DMG_MED),
    .DMG_HEAVY(DMG_HEAVY), .IFRAMES(IFRAMES)
  ) u_ch2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(fighting),
    .hit(hit_p1), .atk(atk_p1), .clear(round_clear),
    .health(health_2), .invuln(invuln_2), .zero_next(zero_2)
  );

  always_comb begin
    state_next    = state_reg;
    ko_cnt_next   = ko_cnt_reg;
    wins_1_next   = wins_1_reg;
    wins_2_next   = wins_2_reg;
    winner_next   = winner_reg;
    ko_pulse_next = 1'b0;
    round_clear   = 1'b0;
    case (state_reg)
      ST_FIGHT: begin
        if (zero_1 || zero_2) begin
          state_next    = ST_KO_HOLD;
          ko_cnt_next   = '0;
          ko_pulse_next = 1'b1;
          if (zero_1 && zero_2) begin
            winner_next = WIN_DRAW;
          end else if (zero_2) begin
            winner_next = WIN_P1;
            if (wins_1_reg < WIN_W'(ROUNDS_TO_WIN)) wins_1_next = wins_1_reg + WIN_W'(1);
          end else begin
            winner_next = WIN_P2;
            if (wins_2_reg < WIN_W'(ROUNDS_TO_WIN)) wins_2_next = wins_2_reg + WIN_W'(1);
          end
        end
      end
      ST_KO_HOLD: begin
        if (frame_tick) begin
          if (ko_cnt_reg == KO_W'(KO_HOLD_FRAMES - 1)) begin
            if ((wins_1_reg == WIN_W'(ROUNDS_TO_WIN)) || (wins_2_reg == WIN_W'(ROUNDS_TO_WIN)))
              state_next = ST_MATCH_OVER;
            else
              state_next = ST_ROUND_END;
          end else begin
            ko_cnt_next = ko_cnt_reg + KO_W'(1);
          end
        end
      end
      ST_ROUND_END: begin
        if (round_start) begin
          round_clear = 1'b1;
          winner_next = WIN_NONE;
          state_next  = ST_FIGHT;
        end
      end
      ST_MATCH_OVER: begin
        if (round_start) begin
          round_clear = 1'b1;
          winner_next = WIN_NONE;
          wins_1_next = '0;
          wins_2_next = '0;
          state_next  = ST_FIGHT;
        end
      end
      default: state_next = ST_FIGHT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_FIGHT;
      ko_cnt_reg   <= '0;
      wins_1_reg   <= '0;
      wins_2_reg   <= '0;
      winner_reg   <= WIN_NONE;
      ko_pulse_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ko_cnt_reg   <= ko_cnt_next;
      wins_1_reg   <= wins_1_next;
      wins_2_reg   <= wins_2_next;
      winner_reg   <= winner_next;
      ko_pulse_reg <= ko_pulse_next;
    end
  end

  assign state    = state_reg;
  assign wins_1   = wins_1_reg;
  assign wins_2   = wins_2_reg;
  assign winner   = winner_reg;
  assign ko_pulse = ko_pulse_reg;

endmodule
